// File: rtl/mmio_settle_monitor.sv
// mmio_settle_monitor: run-time checker for the MMIO store path and fetch stream.
// Each monitored channel waits for its output register to show the last value
// stored to its address within TIMEOUT cycles. The monitor also checks PC
// alignment, counts non-sequential PC steps and runs a cycle watchdog.
// All results are sticky flags or saturating counters.
module mmio_settle_monitor #(
  parameter int              NCH        = 2,
  parameter int              DW         = 32,
  parameter logic [NCH*DW-1:0] CH_ADDR  = {32'h0000_7010, 32'h0000_7000},
  parameter int              TIMEOUT    = 4,
  parameter int              MAX_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_lsu_we,
  input  logic [DW-1:0]     i_lsu_addr,
  input  logic [DW-1:0]     i_lsu_wdata,
  input  logic [NCH*DW-1:0] i_mmio_out,
  input  logic [DW-1:0]     i_pc,
  input  logic              i_insn_vld,
  output logic [NCH-1:0]    o_pending,
  output logic [NCH-1:0]    o_late,
  output logic [15:0]       o_late_cnt,
  output logic [7:0]        o_max_lat,
  output logic              o_pc_misalign,
  output logic [15:0]       o_redirect_cnt,
  output logic              o_seen_vld,
  output logic              o_timeout
);

  // Age counter only needs to reach TIMEOUT.
  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] AGE_ONE  = AW'(1);
  localparam logic [AW-1:0] AGE_LAST = AW'(TIMEOUT);
  localparam logic [31:0]   WD_LIMIT = 32'(MAX_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Clamp a channel age to the 8-bit latency statistic.
  function automatic logic [7:0] sat8(input logic [AW-1:0] a);
    if (32'(a) > 32'd255) return 8'hFF;
    return 8'(a);
  endfunction

  logic [NCH-1:0] hit;
  logic [NCH-1:0] match;
  logic [NCH-1:0] late;
  logic [7:0]     lat_cand [NCH];

  logic [NCH-1:0] late_flags_reg;
  logic [15:0]    late_cnt_reg;
  logic [15:0]    late_cnt_next;
  logic [7:0]     max_lat_reg;
  logic [7:0]     max_lat_next;
  logic [3:0]     late_num;
  logic [16:0]    late_sum;

  logic [DW-1:0]  prev_pc_reg;
  logic           seen_vld_reg;
  logic           misalign_reg;
  logic [15:0]    redirect_cnt_reg;

  logic [31:0]    wd_cnt_reg;
  logic           timeout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [0:0]    state_reg;
      logic [DW-1:0] exp_reg;
      logic [AW-1:0] age_reg;

      // A new store always wins over the check it supersedes.
      assign hit[gi]   = i_lsu_we && (i_lsu_addr == CH_ADDR[gi*DW +: DW]);
      assign match[gi] = (state_reg == ST_WAIT) && !hit[gi] &&
                         (i_mmio_out[gi*DW +: DW] == exp_reg);
      assign late[gi]  = (state_reg == ST_WAIT) && !hit[gi] && !match[gi] &&
                         (age_reg == AGE_LAST);
      assign lat_cand[gi]  = match[gi] ? sat8(age_reg) : 8'd0;
      assign o_pending[gi] = (state_reg == ST_WAIT);

      // Per-channel IDLE/WAIT tracker with captured value and age.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          state_reg <= ST_IDLE;
          exp_reg   <= '0;
          age_reg   <= '0;
        end else if (hit[gi]) begin
          state_reg <= ST_WAIT;
          exp_reg   <= i_lsu_wdata;
          age_reg   <= AGE_ONE;
        end else if (state_reg == ST_WAIT) begin
          if (match[gi] || late[gi]) begin
            state_reg <= ST_IDLE;
          end else begin
            age_reg <= age_reg + AGE_ONE;
          end
        end
      end
    end
  endgenerate

  // Fold per-channel events into the shared late counter and max latency.
  always_comb begin
    late_num     = '0;
    max_lat_next = max_lat_reg;
    for (int k = 0; k < NCH; k++) begin
      late_num = late_num + 4'(late[k]);
      if (lat_cand[k] > max_lat_next) max_lat_next = lat_cand[k];
    end
    late_sum      = {1'b0, late_cnt_reg} + 17'(late_num);
    late_cnt_next = late_sum[16] ? 16'hFFFF : late_sum[15:0];
  end

  // Shared statistics registers for the MMIO checks.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      late_flags_reg <= '0;
      late_cnt_reg   <= '0;
      max_lat_reg    <= '0;
    end else begin
      late_flags_reg <= late_flags_reg | late;
      late_cnt_reg   <= late_cnt_next;
      max_lat_reg    <= max_lat_next;
    end
  end

  // Fetch stream: alignment and non-sequential step tracking on valid cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_pc_reg      <= '0;
      seen_vld_reg     <= 1'b0;
      misalign_reg     <= 1'b0;
      redirect_cnt_reg <= '0;
    end else if (i_insn_vld) begin
      seen_vld_reg <= 1'b1;
      prev_pc_reg  <= i_pc;
      if (i_pc[1:0] != 2'b00) misalign_reg <= 1'b1;
      if (seen_vld_reg && (i_pc != prev_pc_reg + DW'(4)) &&
          (redirect_cnt_reg != 16'hFFFF)) begin
        redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
      end
    end
  end

  // Watchdog: counts edges since reset release, flags at MAX_CYCLES.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (wd_cnt_reg != WD_LIMIT) wd_cnt_reg <= wd_cnt_reg + 32'd1;
      if (wd_cnt_reg + 32'd1 >= WD_LIMIT) timeout_reg <= 1'b1;
    end
  end

  assign o_late         = late_flags_reg;
  assign o_late_cnt     = late_cnt_reg;
  assign o_max_lat      = max_lat_reg;
  assign o_pc_misalign  = misalign_reg;
  assign o_redirect_cnt = redirect_cnt_reg;
  assign o_seen_vld     = seen_vld_reg;
  assign o_timeout      = timeout_reg;

endmodule

// File: doc/mmio_settle_monitor.md
# mmio_settle_monitor

Synthesizable run-time checker for the single-cycle core's MMIO store path and fetch stream, instantiated beside `singlecycle` in benches and optionally on FPGA for self-check. It watches LSU writes to NCH configurable MMIO addresses and requires each addressed output register to reflect the written data within TIMEOUT cycles. It also checks PC alignment and counts non-sequential PC steps, and runs a cycle watchdog. All results are exposed as sticky flags and saturating counters.

## Interface
- NCH, 2, number of monitored MMIO channels (1..8)
- DW, 32, data and address width
- CH_ADDR, {32'h0000_7010, 32'h0000_7000}, packed NCH*DW; channel k address is slice k (ch0 = 0x7000 LEDR, ch1 = 0x7010 LEDG)
- TIMEOUT, 4, max cycles from write to match (>=1)
- MAX_CYCLES, 200000, watchdog limit in cycles after reset release
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_lsu_we  in  1  LSU store strobe, one store per asserted cycle
- i_lsu_addr  in  DW  store address
- i_lsu_wdata  in  DW  store data
- i_mmio_out  in  NCH*DW  observed output register per channel, slice k = channel k
- i_pc  in  DW  fetch PC
- i_insn_vld  in  1  instruction valid this cycle
- o_pending  out  NCH  channel k waiting for match
- o_late  out  NCH  sticky: channel k missed its deadline at least once
- o_late_cnt  out  16  total late events, saturating at 0xFFFF
- o_max_lat  out  8  largest observed write-to-match latency, in cycles
- o_pc_misalign  out  1  sticky: a valid PC had bits [1:0] != 0
- o_redirect_cnt  out  16  valid PC steps != +4, saturating at 0xFFFF
- o_seen_vld  out  1  sticky: i_insn_vld seen since reset
- o_timeout  out  1  sticky: watchdog expired

## Operation
- Reset (rstn=0 at a clk edge) clears every output, channel state, age counters, PC tracking, and the watchdog. It takes effect mid-operation too: a pending check is dropped without raising o_late.
- Each channel runs its own FSM with states IDLE and WAIT, a captured expected value EXP, and an age counter.
  - Write hit: i_lsu_we=1 and i_lsu_addr == CH_ADDR[k]. EXP <= i_lsu_wdata, age <= 1, state <= WAIT. This applies from IDLE or from WAIT.
  - A hit in WAIT restarts the check. The superseded check raises no late flag, even if it matched in the same cycle.
  - In WAIT with no new hit, if i_mmio_out[k] == EXP:
    - state <= IDLE
    - o_max_lat <= max(o_max_lat, age)
  - Otherwise, if age == TIMEOUT:
    - o_late[k] <= 1
    - o_late_cnt increments (saturating)
    - state <= IDLE
  - Otherwise age increments.
  - Non-matching addresses are ignored. If several channels share an address, all of them trigger.
  - If several channels go late in the same cycle, o_late_cnt adds the count of late channels, saturating.
- PC checks apply only on cycles with i_insn_vld=1.
  - The first such cycle after reset only captures PREV <= i_pc and sets o_seen_vld.
  - On each later such cycle:
    - if i_pc != PREV+4 (modulo 2^DW), o_redirect_cnt increments (saturating)
    - PREV <= i_pc
  - o_pc_misalign sets on any valid cycle, including the first, where i_pc[1:0] != 0.
- The watchdog counter increments every cycle after reset and saturates. When it reaches MAX_CYCLES, o_timeout sets and stays set until reset.

## Timing
- All outputs are registered and updated at posedge clk. No combinational input-to-output paths exist.
- Write at edge t: o_pending[k]=1 after edge t. The first compare is at edge t+1 (latency 1). The last compare is at edge t+TIMEOUT.
- A match at edge t+j clears o_pending after that edge and records latency j.
- With no match, o_late[k] is visible after edge t+TIMEOUT.
- If i_mmio_out already equals the written data at the write edge, that does not count. The match is recorded at t+1 with latency 1.
- o_max_lat saturates at 255.
- The watchdog counts edges after the first edge with rstn=1. o_timeout becomes 1 after the MAX_CYCLES-th such edge.

## Test plan
- Write 0x1 to 0x7000, drive ch0 out = 0x1 two cycles later -> o_pending[0] high for 2 cycles, o_max_lat=2, o_late=0.
- Write 0x2 to 0x7010, hold ch1 out = 0 -> o_late[1]=1 after exactly 4 edges, o_late_cnt=1, o_pending[1]=0.
- Write 0x5 to 0x7000, then write 0x6 two cycles later, drive out = 0x6 at age 3 of the second write -> no late, o_max_lat=3.
- Valid PC sequence 0,4,8,0x40,0x44,0x46 -> o_redirect_cnt=2, o_pc_misalign=1, o_seen_vld=1.
- MAX_CYCLES=10, idle stimulus -> o_timeout=0 after edge 9, 1 after edge 10. Assert rstn=0 mid-WAIT -> all outputs 0 the next cycle, no late.
- NCH=3 with channel 2 = 0x7000 as well: write to 0x7000, no match on either channel -> o_late={1,0,1}, o_late_cnt=2.
